pattern_sequencer: RTL and testbench

Playback controller for the pattern ROM: accepts a command (start address, last address, step divider) over a valid/ready handshake and steps the ROM address at the programmed rate from start to last, then signals completion. Replaces the free-running fixed-rate address counter in the top level, so that firmware or a host-side control block can schedule pattern segments at selectable bit rates. Sits between the command source and the ROM read port; the ROM read register stays in the top level.

---
 rtl/pattern_sequencer.sv | 144 ++++++++++++++
 tb/tb_pattern_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_sequencer.sv
`default_nettype none
// ============================================================================
// pattern_sequencer : steps the pattern ROM address from start to last at a
//                     programmed rate; optional multi-pass via PATSEQ_LOOP_EN
// Revision 1.0
// ============================================================================
module pattern_sequencer #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DIV_WIDTH   = 12,
  parameter int DEFAULT_DIV = 2604
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_start,
  input  logic [ADDR_WIDTH-1:0] cmd_last,
  input  logic [DIV_WIDTH-1:0]  cmd_div,
  input  logic [7:0]            cmd_repeat,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_en,
  output logic                  busy,
  output logic                  done
);

  localparam logic [DIV_WIDTH-1:0] C_DEFAULT_DIV = DEFAULT_DIV[DIV_WIDTH-1:0];

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                r_state,  w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr,   w_addr_next;
  logic [ADDR_WIDTH-1:0] r_start,  w_start_next;
  logic [ADDR_WIDTH-1:0] r_last,   w_last_next;
  logic [DIV_WIDTH-1:0]  r_div,    w_div_next;
  logic [DIV_WIDTH-1:0]  r_presc,  w_presc_next;
  logic                  r_en,     w_en_next;
  logic                  r_done,   w_done_next;
  logic                  w_accept;
  logic                  w_more_passes;

`ifdef PATSEQ_LOOP_EN
  logic [7:0] r_rem, w_rem_next;
  assign w_more_passes = (r_rem != 8'd0);
`else
  logic w_unused_repeat;
  assign w_unused_repeat = ^cmd_repeat;
  assign w_more_passes   = 1'b0;
`endif

  assign cmd_ready = (r_state == S_IDLE) && !abort;
  assign w_accept  = cmd_valid && cmd_ready;
  assign rom_addr  = r_addr;
  assign rom_en    = r_en;
  assign busy      = (r_state == S_RUN);
  assign done      = r_done;

  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_start_next = r_start;
    w_last_next  = r_last;
    w_div_next   = r_div;
    w_presc_next = r_presc;
    w_en_next    = 1'b0;
    w_done_next  = 1'b0;
`ifdef PATSEQ_LOOP_EN
    w_rem_next   = r_rem;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = S_RUN;
          w_addr_next  = cmd_start;
          w_start_next = cmd_start;
          w_last_next  = cmd_last;
          w_div_next   = (cmd_div == '0) ? C_DEFAULT_DIV : cmd_div;
          w_presc_next = '0;
          w_en_next    = 1'b1;
`ifdef PATSEQ_LOOP_EN
          w_rem_next   = cmd_repeat;
`endif
        end
      end
      S_RUN: begin
        // Abort wins over a coincident step: no rom_en, address holds.
        if (abort) begin
          w_state_next = S_IDLE;
        end else if (r_presc == r_div) begin
          w_presc_next = '0;
          if (r_addr != r_last) begin
            w_addr_next = r_addr + 1'b1;
            w_en_next   = 1'b1;
          end else if (w_more_passes) begin
            w_addr_next = r_start;
            w_en_next   = 1'b1;
`ifdef PATSEQ_LOOP_EN
            w_rem_next  = r_rem - 8'd1;
`endif
          end else begin
            w_state_next = S_IDLE;
            w_done_next  = 1'b1;
          end
        end else begin
          w_presc_next = r_presc + 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_start <= '0;
      r_last  <= '0;
      r_div   <= '0;
      r_presc <= '0;
      r_en    <= 1'b0;
      r_done  <= 1'b0;
`ifdef PATSEQ_LOOP_EN
      r_rem   <= 8'd0;
`endif
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
      r_start <= w_start_next;
      r_last  <= w_last_next;
      r_div   <= w_div_next;
      r_presc <= w_presc_next;
      r_en    <= w_en_next;
      r_done  <= w_done_next;
`ifdef PATSEQ_LOOP_EN
      r_rem   <= w_rem_next;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// tb_pattern_sequencer : self-checking bench for pattern_sequencer
// Revision 1.0
// ============================================================================
module tb_pattern_sequencer;

  localparam int DEF = 2604;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_start;
  logic [7:0]  cmd_last;
  logic [11:0] cmd_div;
  logic [7:0]  cmd_repeat;
  logic        abort;
  logic [7:0]  rom_addr;
  logic        rom_en;
  logic        busy;
  logic        done;

  int n_cmp  = 0;
  int n_fail = 0;

  pattern_sequencer #(.ADDR_WIDTH(8), .DIV_WIDTH(12), .DEFAULT_DIV(DEF)) dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_last(cmd_last), .cmd_div(cmd_div),
    .cmd_repeat(cmd_repeat), .abort(abort), .rom_addr(rom_addr),
    .rom_en(rom_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int passes(input int rep);
`ifdef PATSEQ_LOOP_EN
    return rep + 1;
`else
    return 1;
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; cmd_valid = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  // Drives a command (unless already presented), then checks every cycle of
  // the run against the expected address schedule. With chain set, the next
  // command is presented in the done cycle.
  task automatic run_cmd(input int s, input int l, input int d, input int r,
                         input bit preloaded, input bit noise, input bit chain,
                         input int cs, input int cl, input int cd, input int cr);
    int D, L, P, T, idx, kmax;
    logic [7:0] ea;
    logic een, ebusy, edone, erdy;
    bit bad;
    D = (d == 0) ? DEF : d;
    L = ((l - s) & 255) + 1;
    P = passes(r);
    T = P * L * (D + 1);
    kmax = chain ? T : T + 1;
    bad = 1'b0;
    if (!preloaded) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_start = 8'(s); cmd_last = 8'(l);
      cmd_div = 12'(d); cmd_repeat = 8'(r);
    end
    @(posedge clk);
    for (int k = 0; k <= kmax; k++) begin
      @(negedge clk);
      if (k < T) begin
        idx = k / (D + 1);
        ea = 8'(s + (idx % L)); een = (k % (D + 1) == 0);
        ebusy = 1'b1; edone = 1'b0; erdy = 1'b0;
      end else begin
        ea = 8'(l); een = 1'b0; ebusy = 1'b0; edone = (k == T); erdy = 1'b1;
      end
      n_cmp++;
      if ({rom_addr, rom_en, busy, done, cmd_ready} !== {ea, een, ebusy, edone, erdy}) begin
        n_fail++;
        bad = 1'b1;
        $display("FAIL run(s=%0d l=%0d d=%0d r=%0d) cycle %0d: got addr=%0d en=%b busy=%b done=%b rdy=%b, want addr=%0d en=%b busy=%b done=%b rdy=%b",
                 s, l, d, r, k, rom_addr, rom_en, busy, done, cmd_ready, ea, een, ebusy, edone, erdy);
        break;
      end
      if (chain && k == T) begin
        cmd_valid = 1'b1; cmd_start = 8'(cs); cmd_last = 8'(cl);
        cmd_div = 12'(cd); cmd_repeat = 8'(cr);
      end else if (noise && k < T) begin
        cmd_valid = 1'($urandom_range(0, 1)); cmd_start = 8'($urandom);
        cmd_last = 8'($urandom); cmd_div = 12'($urandom_range(1, 3));
        cmd_repeat = 8'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
    end
    if (bad) begin
      do_reset();
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; cmd_valid = 1'b0; abort = 1'b0;
    cmd_start = '0; cmd_last = '0; cmd_div = '0; cmd_repeat = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({rom_addr, rom_en, busy, done} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_state: got addr=%0d en=%b busy=%b done=%b, want all 0",
               rom_addr, rom_en, busy, done);
    end
    resetn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({rom_addr, rom_en, busy, done, cmd_ready} !== {8'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL idle_after_reset: got addr=%0d en=%b busy=%b done=%b rdy=%b, want 0/0/0/0/1",
               rom_addr, rom_en, busy, done, cmd_ready);
    end
  endtask

  task automatic test_basic();
    run_cmd(0, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cmd(7, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cmd(254, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_loop();
    run_cmd(5, 6, 1, 2, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_abort();
    logic [7:0] ea;
    // Run 0..5 with div 3; abort in the second cycle of address 2.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_start = 8'd0; cmd_last = 8'd5; cmd_div = 12'd3; cmd_repeat = 8'd0;
    @(posedge clk);
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      ea = 8'(k / 4);
      n_cmp++;
      if (rom_addr !== ea || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL abort_prelude cycle %0d: got addr=%0d busy=%b, want addr=%0d busy=1",
                 k, rom_addr, busy, ea);
      end
      if (k == 9) abort = 1'b1;
    end
    @(negedge clk);
    n_cmp++;
    if ({rom_addr, rom_en, busy, done} !== {8'd2, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_run: got addr=%0d en=%b busy=%b done=%b, want 2/0/0/0",
               rom_addr, rom_en, busy, done);
    end
    abort = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({rom_addr, rom_en, busy, done, cmd_ready} !== {8'd2, 1'b0, 1'b0, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL abort_idle_hold %0d: got addr=%0d en=%b busy=%b done=%b rdy=%b, want 2/0/0/0/1",
                 k, rom_addr, rom_en, busy, done, cmd_ready);
      end
    end
    // abort in IDLE blocks acceptance that cycle
    cmd_valid = 1'b1; abort = 1'b1; cmd_start = 8'd9; cmd_last = 8'd9; cmd_div = 12'd1;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_blocks_ready: got rdy=%b, want 0", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0; abort = 1'b0;
    n_cmp++;
    if ({rom_addr, rom_en, busy} !== {8'd2, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_idle_no_accept: got addr=%0d en=%b busy=%b, want 2/0/0",
               rom_addr, rom_en, busy);
    end
  endtask

  task automatic test_midrun_reset();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_start = 8'd10; cmd_last = 8'd20; cmd_div = 12'd2; cmd_repeat = 8'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (7) @(negedge clk);
    resetn = 1'b0;
    #1;
    n_cmp++;
    if ({rom_addr, rom_en, busy, done} !== 11'd0) begin
      n_fail++;
      $display("FAIL midrun_reset: got addr=%0d en=%b busy=%b done=%b, want all 0",
               rom_addr, rom_en, busy, done);
    end
    @(negedge clk);
    resetn = 1'b1;
    run_cmd(3, 4, 2, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_cmd(20, 22, 2, 1, 0, 0, 1, 40, 41, 3, 0);
    run_cmd(40, 41, 3, 0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_busy_ignore();
    run_cmd(100, 103, 2, 1, 0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    int s, l, d, r;
    for (int i = 0; i < 10; i++) begin
      s = int'($urandom_range(0, 255));
      l = (s + int'($urandom_range(0, 5))) & 255;
      d = int'($urandom_range(1, 6));
      r = int'($urandom_range(0, 3));
      run_cmd(s, l, d, r, 0, i[0], 0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_loop();
    test_abort();
    test_midrun_reset();
    test_back_to_back();
    test_busy_ignore();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
